// File: rtl/regfile_rd_port_if.sv
// Operand-issue bus for regfile_rd_port.
// Groups three channels:
//   request  : req_valid/req_ready, req_rs1/req_rs2/req_rd, req_alloc
//   packet   : pkt_valid/pkt_ready, rs1_val/rs2_val
//   writeback: wb_valid, wb_addr, wb_data
// The master modport is the issuing/ALU side. The slave modport is the register file.
interface regfile_rd_port_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_rs1;
  logic [AW-1:0]   req_rs2;
  logic [AW-1:0]   req_rd;
  logic            req_alloc;
  logic            pkt_valid;
  logic            pkt_ready;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_alloc,
    output pkt_ready,
    output wb_valid, wb_addr, wb_data,
    input  req_ready, pkt_valid, rs1_val, rs2_val
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_alloc,
    input  pkt_ready,
    input  wb_valid, wb_addr, wb_data,
    output req_ready, pkt_valid, rs1_val, rs2_val
  );
endinterface

// File: rtl/regfile_rd_port.sv
// Integer register file and operand-issue stage.
// It holds x0..x31 (x0 reads as zero) and has one writeback port. A pending-bit
// scoreboard stalls requests on RAW/WAW hazards. Operands leave through a
// registered valid/ready stage with 1-cycle latency.
// Ports:
//   clk, rst_n : clock (rising edge) and async active-low reset
//   bus        : request / operand packet / writeback channels (slave side)
//   pending    : scoreboard, bit i set while xi has an outstanding write
//   stall_cnt  : saturating count of cycles with req_valid & !req_ready
module regfile_rd_port #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_rd_port_if.slave bus,
  output logic [NREGS-1:0] pending,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW-1:0]    ADDR_X0 = '0;

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pending;
  logic             r_pkt_valid;
  logic [XLEN-1:0]  r_rs1_val;
  logic [XLEN-1:0]  r_rs2_val;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_clr_rs1;
  logic             w_clr_rs2;
  logic             w_clr_rd;
  logic             w_hazard;
  logic             w_ready;
  logic             w_accept;
  logic             w_wr_en;
  logic [XLEN-1:0]  w_rs1_op;
  logic [XLEN-1:0]  w_rs2_op;
  logic [NREGS-1:0] w_pending_nxt;

  // Writebacks this cycle clear a pending source, so they do not cause a stall.
  assign w_clr_rs1 = bus.wb_valid && (bus.wb_addr == bus.req_rs1);
  assign w_clr_rs2 = bus.wb_valid && (bus.wb_addr == bus.req_rs2);
  assign w_clr_rd  = bus.wb_valid && (bus.wb_addr == bus.req_rd);

  assign w_hazard = (r_pending[bus.req_rs1] && !w_clr_rs1) ||
                    (r_pending[bus.req_rs2] && !w_clr_rs2) ||
                    (bus.req_alloc && r_pending[bus.req_rd] && !w_clr_rd);

  assign w_ready  = (!r_pkt_valid || bus.pkt_ready) && !w_hazard;
  assign w_accept = bus.req_valid && w_ready;
  assign w_wr_en  = bus.wb_valid && (bus.wb_addr != ADDR_X0);

  // Operand select: x0 is zero, then the same-cycle writeback bypass, then the array.
  always_comb begin
    w_rs1_op = r_regs[bus.req_rs1];
    w_rs2_op = r_regs[bus.req_rs2];
    if (bus.req_rs1 == ADDR_X0) w_rs1_op = '0;
    else if (w_clr_rs1)         w_rs1_op = bus.wb_data;
    if (bus.req_rs2 == ADDR_X0) w_rs2_op = '0;
    else if (w_clr_rs2)         w_rs2_op = bus.wb_data;
  end

  // Scoreboard update. The set is applied after the clear, so a set wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wr_en) w_pending_nxt[bus.wb_addr] = 1'b0;
    if (w_accept && bus.req_alloc && (bus.req_rd != ADDR_X0))
      w_pending_nxt[bus.req_rd] = 1'b1;
  end

  // Register array. Index 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  // Output stage: load on accept, drain on consume, otherwise hold stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_valid <= 1'b0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
    end else if (w_accept) begin
      r_pkt_valid <= 1'b1;
      r_rs1_val   <= w_rs1_op;
      r_rs2_val   <= w_rs2_op;
    end else if (bus.pkt_ready) begin
      r_pkt_valid <= 1'b0;
    end
  end

  // Saturating stall counter. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (bus.req_valid && !w_ready && (r_stall_cnt != CNT_MAX))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.req_ready = w_ready;
  assign bus.pkt_valid = r_pkt_valid;
  assign bus.rs1_val   = r_rs1_val;
  assign bus.rs2_val   = r_rs2_val;
  assign pending       = r_pending;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: doc/regfile_rd_port.md
Name: regfile_rd_port

Overview:
- Integer register file and operand-issue stage that produces the `{rs1_val, rs2_val}` operand packet consumed by the ALU.
- Holds x0..x31 and accepts ALU/writeback results on one write port.
- Tracks in-flight destinations with a pending-bit scoreboard and stalls operand issue on RAW/WAW hazards.
- Presents operands through a registered valid/ready output stage with 1-cycle latency.

Parameters:
- XLEN, 32, data width of each register and operand.
- NREGS, 32, number of architectural registers (x0 hardwired zero).
- AW, 5, register address width; must equal clog2(NREGS).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  operand-read request valid.
- req_ready  output  1  request accepted this cycle when req_valid & req_ready.
- req_rs1  input  AW  source register 1 address.
- req_rs2  input  AW  source register 2 address.
- req_rd  input  AW  destination register of the issuing instruction.
- req_alloc  input  1  instruction will write req_rd; mark it pending.
- pkt_valid  output  1  operand packet valid.
- pkt_ready  input  1  ALU stage consumes the packet.
- rs1_val  output  XLEN  operand 1 (regfile_pkt.rs1_val).
- rs2_val  output  XLEN  operand 2 (regfile_pkt.rs2_val).
- wb_valid  input  1  writeback valid.
- wb_addr  input  AW  writeback destination.
- wb_data  input  XLEN  writeback data (ALU result).
- pending  output  NREGS  scoreboard bits, bit i = xi pending.
- stall_cnt  output  CNT_W  saturating count of stalled request cycles.

Behaviour:
- **Reset:** async on rst_n low. All registers are 0, pending = 0, pkt_valid = 0, rs1_val = rs2_val = 0, stall_cnt = 0. A reset mid-operation drops any held packet and all pending bits.
- **x0:**
  - Reads return 0.
  - Writes with wb_addr = 0 are ignored.
  - Alloc with req_rd = 0 sets nothing, so pending[0] is always 0.
- **Clear-this-cycle term:** clr(a) = wb_valid & (wb_addr == a).
- **Hazard:** hazard = (pending[rs1] & !clr(rs1)) | (pending[rs2] & !clr(rs2)) | (req_alloc & pending[rd] & !clr(rd)).
- **Ready:** req_ready = (!pkt_valid | pkt_ready) & !hazard. It is combinational and does not depend on req_valid.
- **Accept:**
  - On req_valid & req_ready, the rs1_val/rs2_val registers load next edge and pkt_valid goes to 1. Latency from accept to pkt_valid is 1 cycle.
  - Operand select: if the address is 0, the operand is 0. Else if clr(address) & address != 0, it is wb_data (same-cycle bypass). Else it is the array value.
- **Hold:** while pkt_valid & !pkt_ready, rs1_val/rs2_val/pkt_valid hold stable, regardless of writebacks to those sources.
- **Drain:** pkt_ready with no accept gives pkt_valid = 0 next cycle. Accept and pkt_ready together give back-to-back packets at full throughput, 1 per cycle.
- **Writeback:** wb_valid & wb_addr != 0 writes the array and clears pending[wb_addr] next edge. A writeback to a non-pending register is legal and simply writes.
- **Scoreboard set:** an accept with req_alloc & req_rd != 0 sets pending[req_rd] next edge.
  - Same-cycle set and clear of the same address: set wins, and the array still takes wb_data.
- **stall_cnt:** increments each cycle where req_valid & !req_ready, saturating at 2^CNT_W-1. It is never cleared except by reset.
- The request side must hold fields stable while req_valid & !req_ready; behaviour otherwise is undefined.

Test Plan:
1. **Reset, read, operand order:**
   - Reset, then write x5=0x0000_00AA and x6=0xFFFF_FF00 via wb.
   - Request rs1=5, rs2=6.
   - Expect pkt_valid 1 cycle later with rs1_val=0xAA and rs2_val=0xFFFFFF00.
2. **x0 handling:**
   - wb x0=0xDEADBEEF, then request rs1=0, rs2=0 with alloc rd=0.
   - Expect both operands = 0 and pending = 0.
3. **RAW stall and bypass:**
   - Accept a request with alloc rd=7, then request rs1=7 for 3 cycles with no wb.
   - Expect req_ready=0 and stall_cnt=3.
   - In cycle 4, wb x7=0x1234 in the same cycle: expect accept, rs1_val=0x1234, pending[7]=0.
4. **Output backpressure:**
   - Hold pkt_ready=0 with a packet rs1_val=0x11, then present a new request and wb to that source.
   - Expect req_ready=0 and rs1_val held at 0x11.
   - Raise pkt_ready: expect the new packet next cycle.
5. **Set-wins collision:**
   - Pending x9; wb x9=0x55 in the same cycle as an accept with alloc rd=9.
   - Expect pending[9]=1 and a later read of x9 stalls until the next wb.
6. **Asynchronous reset mid-operation:**
   - Assert rst_n low mid-cycle with pkt_valid=1 and pending[3]=1.
   - Expect pkt_valid=0, pending=0 and rs1_val=0 immediately, without a clock edge.
